multicycle_control: RTL and testbench

Multi-cycle sequencing controller for the RV32 core. It replaces single-cycle opcode decode with a registered FSM that steps the shared datapath through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It handshakes with instruction/data memory through `mem_ready` and enters a sticky fault state on an illegal opcode or a memory timeout. It sits between the instruction register, the register file, the ALU, the PC mux and the unified memory port.

---
 rtl/multicycle_control.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 sequencing controller: steps the shared datapath through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and parks in a sticky FAULT state.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       take_branch,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] mem_to_reg,
    output logic       instr_done,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd7
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Counter is at least 4 bits and grows if the timeout needs more.
    localparam int unsigned CNT_W     = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
    localparam int unsigned LIMIT_INT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
    localparam logic [CNT_W-1:0] LIMIT = LIMIT_INT[CNT_W-1:0];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_hit;

    logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;
    logic       instr_done_c, fault_c;
    logic [1:0] pc_src_c, alu_src_a_c, alu_src_b_c, alu_op_c, mem_to_reg_c;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        pc_src_c     = 2'b00;
        ir_write_c   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        mem_to_reg_c = 2'b00;
        instr_done_c = 1'b0;
        fault_c      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end

            S_DECODE: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                case (opcode)
                    OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE,
                    OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EXECUTE;
                    default:                    state_d = S_FAULT;
                endcase
            end

            S_EXECUTE: begin
                case (opcode)
                    OP_RTYPE: begin
                        alu_src_a_c = 2'b01;
                        alu_op_c    = 2'b10;
                        state_d     = S_WRITEBACK;
                    end
                    OP_ITYPE: begin
                        alu_src_a_c = 2'b01;
                        alu_src_b_c = 2'b01;
                        alu_op_c    = 2'b11;
                        state_d     = S_WRITEBACK;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a_c = 2'b01;
                        alu_src_b_c = 2'b01;
                        state_d     = S_MEMORY;
                    end
                    OP_BRANCH: begin
                        alu_src_a_c  = 2'b01;
                        alu_op_c     = 2'b01;
                        pc_write_c   = take_branch;
                        pc_src_c     = take_branch ? 2'b01 : 2'b00;
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = 2'b01;
                        state_d    = S_WRITEBACK;
                    end
                    OP_JALR: begin
                        alu_src_a_c = 2'b01;
                        alu_src_b_c = 2'b01;
                        pc_write_c  = 1'b1;
                        pc_src_c    = 2'b10;
                        state_d     = S_WRITEBACK;
                    end
                    default: state_d = S_FAULT;
                endcase
            end

            S_MEMORY: begin
                case (opcode)
                    OP_LOAD: begin
                        mem_read_c = 1'b1;
                        if (mem_ready)        state_d = S_WRITEBACK;
                        else if (timeout_hit) state_d = S_FAULT;
                    end
                    OP_STORE: begin
                        mem_write_c = 1'b1;
                        if (mem_ready) begin
                            instr_done_c = 1'b1;
                            state_d      = S_FETCH;
                        end else if (timeout_hit) begin
                            state_d = S_FAULT;
                        end
                    end
                    default: state_d = S_FAULT;
                endcase
            end

            S_WRITEBACK: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
                case (opcode)
                    OP_LOAD:         mem_to_reg_c = 2'b01;
                    OP_JAL, OP_JALR: mem_to_reg_c = 2'b10;
                    default:         mem_to_reg_c = 2'b00;
                endcase
            end

            S_FAULT: fault_c = 1'b1;

            default: state_d = S_FAULT;
        endcase
    end

    // Waits are counted per state visit; any transition restarts the count.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEMORY) && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Outputs are forced low for as long as reset is held, not just at the edge.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        mem_to_reg = 2'b00;
        instr_done = 1'b0;
        fault      = 1'b0;
        state      = 3'd0;
        if (!reset) begin
            pc_write   = pc_write_c;
            pc_src     = pc_src_c;
            ir_write   = ir_write_c;
            mem_read   = mem_read_c;
            mem_write  = mem_write_c;
            reg_write  = reg_write_c;
            alu_src_a  = alu_src_a_c;
            alu_src_b  = alu_src_b_c;
            alu_op     = alu_op_c;
            mem_to_reg = mem_to_reg_c;
            instr_done = instr_done_c;
            fault      = fault_c;
            state      = state_q;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, the
// illegal-opcode fault and the memory timeout boundary with fixed expectations.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       take_branch;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, instr_done, fault;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
    logic [2:0] state;

    int compared   = 0;
    int mismatched = 0;

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .take_branch(take_branch),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .fault      (fault),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enables();
        return {pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
                alu_src_a, alu_src_b, alu_op, mem_to_reg, instr_done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        opcode      = 7'd0;
        take_branch = 1'b0;
        mem_ready   = 1'b0;
        tick();
        tick();
        check("reset_state", state, 0);
        check("reset_enables", enables(), 0);
        check("reset_fault", fault, 0);

        reset = 1'b0;
        #1;
        check("post_reset_state", state, 0);
        check("post_reset_mem_read", mem_read, 1);
        tick();
        tick();
        check("fetch_wait_state", state, 0);
        check("fetch_wait_mem_read", mem_read, 1);
        check("fetch_wait_ir_write", ir_write, 0);

        #2 reset = 1'b1;
        #1;
        check("async_reset_enables", enables(), 0);
        check("async_reset_state", state, 0);
        tick();
        reset = 1'b0;

        // R-type
        mem_ready = 1'b1;
        opcode    = 7'b0110011;
        #1;
        check("r_fetch_state", state, 0);
        check("r_fetch_enables", enables(), 16'b1_00_1_1_0_0_00_10_00_00_0);
        tick();
        check("r_decode_state", state, 1);
        check("r_decode_enables", enables(), 16'b0_00_0_0_0_0_10_01_00_00_0);
        tick();
        check("r_exec_state", state, 2);
        check("r_exec_enables", enables(), 16'b0_00_0_0_0_0_01_00_10_00_0);
        tick();
        check("r_wb_state", state, 4);
        check("r_wb_reg_write", reg_write, 1);
        check("r_wb_mem_to_reg", mem_to_reg, 0);
        check("r_wb_instr_done", instr_done, 1);
        tick();
        check("r_done_state", state, 0);
        check("r_done_instr_done", instr_done, 0);
        check("r_done_reg_write", reg_write, 0);

        // Load with three wait cycles in MEMORY
        opcode = 7'b0000011;
        tick();
        check("ld_decode_state", state, 1);
        tick();
        check("ld_exec_state", state, 2);
        check("ld_exec_srcs", {alu_src_a, alu_src_b, alu_op}, 6'b01_01_00);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ld_mem_wait_state", state, 3);
            check("ld_mem_wait_mem_read", mem_read, 1);
            check("ld_mem_wait_done", instr_done, 0);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        check("ld_mem_ready_state", state, 3);
        check("ld_mem_ready_mem_read", mem_read, 1);
        tick();
        check("ld_wb_state", state, 4);
        check("ld_wb_mem_to_reg", mem_to_reg, 1);
        check("ld_wb_reg_write", reg_write, 1);
        check("ld_wb_instr_done", instr_done, 1);
        tick();
        check("ld_done_state", state, 0);

        // Branch taken then not taken
        opcode      = 7'b1100011;
        take_branch = 1'b1;
        tick();
        tick();
        check("br_t_exec_state", state, 2);
        check("br_t_pc_write", pc_write, 1);
        check("br_t_pc_src", pc_src, 1);
        check("br_t_alu_op", alu_op, 1);
        check("br_t_instr_done", instr_done, 1);
        tick();
        check("br_t_done_state", state, 0);
        take_branch = 1'b0;
        tick();
        tick();
        #1;
        check("br_nt_exec_state", state, 2);
        check("br_nt_pc_write", pc_write, 0);
        check("br_nt_instr_done", instr_done, 1);
        tick();
        check("br_nt_done_state", state, 0);

        // jal
        opcode = 7'b1101111;
        tick();
        tick();
        check("jal_exec_state", state, 2);
        check("jal_exec_pc", {pc_write, pc_src}, 3'b1_01);
        check("jal_exec_srcs", {alu_src_a, alu_src_b, alu_op}, 6'b00_00_00);
        tick();
        check("jal_wb_state", state, 4);
        check("jal_wb_mem_to_reg", mem_to_reg, 2);
        tick();
        check("jal_done_state", state, 0);

        // jalr
        opcode = 7'b1100111;
        tick();
        tick();
        check("jalr_exec_pc", {pc_write, pc_src}, 3'b1_10);
        check("jalr_exec_srcs", {alu_src_a, alu_src_b, alu_op}, 6'b01_01_00);
        tick();
        check("jalr_wb_mem_to_reg", mem_to_reg, 2);
        check("jalr_wb_instr_done", instr_done, 1);
        tick();
        check("jalr_done_state", state, 0);

        // Zero-wait store
        opcode = 7'b0100011;
        tick();
        tick();
        tick();
        check("st_mem_state", state, 3);
        check("st_mem_enables", enables(), 16'b0_00_0_0_1_0_00_00_00_00_1);
        tick();
        check("st_done_state", state, 0);

        // Timeout: FETCH entered at the previous edge, mem_ready held low
        mem_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("to_fetch_state", state, 0);
        end
        tick();
        check("to_fault_state", state, 7);
        check("to_fault_flag", fault, 1);

        // Reset recovery, then mem_ready arriving on the 15th wait cycle
        #2 reset = 1'b1;
        #1;
        check("to_reset_state", state, 0);
        check("to_reset_fault", fault, 0);
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("to_edge_fetch_state", state, 0);
        end
        mem_ready = 1'b1;
        opcode    = 7'b1111111;
        #1;
        check("to_edge_ir_write", ir_write, 1);
        tick();
        check("to_edge_decode_state", state, 1);
        check("to_edge_fault", fault, 0);

        // Illegal opcode in DECODE
        tick();
        check("ill_state", state, 7);
        check("ill_fault", fault, 1);
        check("ill_enables", enables(), 0);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            tick();
            check("ill_sticky_state", state, 7);
        end
        check("ill_sticky_fault", fault, 1);
        #2 reset = 1'b1;
        tick();
        reset     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 7'b0110011;
        #1;
        check("ill_recover_state", state, 0);
        check("ill_recover_fault", fault, 0);

        // Reset during WRITEBACK must suppress reg_write
        tick();
        tick();
        tick();
        check("mid_wb_reg_write", reg_write, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_reg_write", reg_write, 0);
        check("mid_reset_state", state, 0);
        tick();
        reset = 1'b0;
        #1;
        check("mid_after_state", state, 0);
        check("mid_after_reg_write", reg_write, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
